// File: rtl/vector_seq_ctrl_pkg.sv
// Package: vector_seq_pkg
// Shared types and constants for the vector sequencing controller.
//   A_W / B_W      DUT input / output widths
//   CNT_W          width of the vector, error and index counters
//   DEF_LATENCY    default DUT pipeline depth in clk edges
//   seq_state_e    controller FSM states
//   seq_entry_t    delay-line entry {valid, exp, idx}
//   sat_inc()      saturating counter increment
package vector_seq_pkg;

    localparam int A_W         = 5;
    localparam int B_W         = 2;
    localparam int CNT_W       = 16;
    localparam int DEF_LATENCY = 2;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ALL1 = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic             valid;
        logic [B_W-1:0]   exp;
        logic [CNT_W-1:0] idx;
    } seq_entry_t;

    localparam seq_entry_t ENTRY_EMPTY = '{valid: 1'b0, exp: {B_W{1'b0}}, idx: CNT_ZERO};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_ALL1) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

endpackage

// File: rtl/vector_seq_ctrl_if.sv
// Interface: vector_seq_ctrl_if
// Vector request stream from the requester into the sequencing controller.
//   s_valid  requester has a vector
//   s_ready  controller accepts the vector this cycle
//   s_data   stimulus vector for the DUT
//   s_exp    expected DUT output for that vector
// master = requester side, slave = controller side.
interface vector_seq_ctrl_if;
    import vector_seq_pkg::*;

    logic           s_valid;
    logic           s_ready;
    logic [A_W-1:0] s_data;
    logic [B_W-1:0] s_exp;

    modport master (output s_valid, output s_data, output s_exp, input s_ready);
    modport slave  (input s_valid, input s_data, input s_exp, output s_ready);

endinterface

// File: rtl/vector_seq_ctrl_delay_line.sv
// Module: seq_delay_line
// Shift register that carries {valid, exp, idx} alongside the DUT pipeline.
// Stage 0 is loaded on the same edge as the dut_a register, and LATENCY more
// shifts bring the entry to the output stage exactly when dut_b reflects it.
//   clk, rst    clock, asynchronous active-high reset
//   push        entry issued this cycle (valid=0 for bubbles / idle)
//   out_entry   entry to compare against dut_b this cycle
//   any_valid   some entry other than the output stage still awaits its compare
module seq_delay_line
    import vector_seq_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic       clk,
    input  logic       rst,
    input  seq_entry_t push,
    output seq_entry_t out_entry,
    output logic       any_valid
);

    seq_entry_t stage_r [0:LATENCY];

    // Advance every stage by one each clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                stage_r[i] <= ENTRY_EMPTY;
            end
        end else begin
            stage_r[0] <= push;
            for (int i = 1; i <= LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_entry = stage_r[LATENCY];

    // The output stage is consumed this cycle, so only earlier stages keep the run alive.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | stage_r[i].valid;
        end
    end

endmodule

// File: rtl/vector_seq_ctrl.sv
// Module: vector_seq_ctrl
// Feeds (vector, expected) pairs into a pipelined DUT, compares its output
// LATENCY edges after each issue and reports mismatch count and first failing index.
//   clk, rst     shared clock, asynchronous active-high reset
//   start        begins a run (IDLE only); num_vec sampled with it
//   s_if         vector request stream (slave side)
//   dut_a        registered drive to the DUT input
//   dut_b        DUT output
//   busy         high in RUN and DRAIN
//   done         one-cycle pulse at the end of a run
//   err_cnt      saturating mismatch count of the current / last run
//   first_fail   index of the first mismatching vector, all-ones if none
module vector_seq_ctrl
    import vector_seq_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    vector_seq_ctrl_if.slave s_if,
    output logic [A_W-1:0]   dut_a,
    input  logic [B_W-1:0]   dut_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail
);

    seq_state_e       state_r;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] issue_idx_r;
    logic [A_W-1:0]   dut_a_r;
    logic             s_ready_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] first_fail_r;

    logic             fire_s;
    logic             any_valid_s;
    logic             cmp_fail_s;
    seq_entry_t       push_s;
    seq_entry_t       cmp_entry_s;

    // s_ready_r is high exactly while the FSM sits in RUN.
    assign fire_s     = s_if.s_valid && s_ready_r;
    assign push_s     = '{valid: fire_s, exp: s_if.s_exp, idx: issue_idx_r};
    assign cmp_fail_s = cmp_entry_s.valid && (dut_b != cmp_entry_s.exp);

    seq_delay_line #(.LATENCY(LATENCY)) u_delay (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .out_entry (cmp_entry_s),
        .any_valid (any_valid_s)
    );

    // Run FSM together with issue, compare accounting and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            remaining_r  <= CNT_ZERO;
            issue_idx_r  <= CNT_ZERO;
            dut_a_r      <= {A_W{1'b0}};
            s_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_cnt_r    <= CNT_ZERO;
            first_fail_r <= CNT_ALL1;
        end else begin
            done_r <= 1'b0;

            // Compare result lands first; a start in IDLE below overrides it.
            if (cmp_fail_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
                if (first_fail_r == CNT_ALL1) begin
                    first_fail_r <= cmp_entry_s.idx;
                end else begin
                    first_fail_r <= first_fail_r;
                end
            end else begin
                err_cnt_r <= err_cnt_r;
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        err_cnt_r    <= CNT_ZERO;
                        first_fail_r <= CNT_ALL1;
                        issue_idx_r  <= CNT_ZERO;
                        if (num_vec != CNT_ZERO) begin
                            state_r     <= RUN;
                            remaining_r <= num_vec;
                            s_ready_r   <= 1'b1;
                            busy_r      <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (fire_s) begin
                        dut_a_r     <= s_if.s_data;
                        issue_idx_r <= issue_idx_r + CNT_ONE;
                        remaining_r <= remaining_r - CNT_ONE;
                        if (remaining_r == CNT_ONE) begin
                            state_r   <= DRAIN;
                            s_ready_r <= 1'b0;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    if (!any_valid_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    s_ready_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.s_ready = s_ready_r;
    assign dut_a        = dut_a_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_cnt      = err_cnt_r;
    assign first_fail   = first_fail_r;

endmodule

// File: tb/tb_vector_seq_ctrl.sv
// Testbench for vector_seq_ctrl: directed run table, reset / empty-run
// sequences and randomized runs scored against a run-level reference.
module tb_vector_seq_ctrl;
    import vector_seq_pkg::*;

    localparam int LAT    = 2;
    localparam int BUDGET = 400;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = 16'd0;
    logic [A_W-1:0]   dut_a;
    logic [B_W-1:0]   dut_b;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_fail;

    vector_seq_ctrl_if vif ();

    vector_seq_ctrl #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .s_if       (vif),
        .dut_a      (dut_a),
        .dut_b      (dut_b),
        .busy       (busy),
        .done       (done),
        .err_cnt    (err_cnt),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    // Stand-in gate-level DUT: combinational function followed by LAT pipeline registers.
    function automatic logic [1:0] gate_f(input logic [4:0] a);
        return {(a[4] & a[1]) | (~a[3] & a[0]), ^a};
    endfunction

    logic [1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= gate_f(dut_a);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dut_b = pipe[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [4:0] data_a [64];
    logic [1:0] exp_a  [64];
    int         gap_a  [64];

    // One run; vector i is preceded by gap_a[i] bubble cycles. Returns edges from
    // the start edge to the edge that raises done (-1 on timeout) plus the results.
    task automatic run_once(input int n, input bit poke, output int cycles,
                            output logic [15:0] err, output logic [15:0] ff);
        int k;
        int i;
        int gap;
        @(negedge clk);
        start   = 1'b1;
        num_vec = 16'(n);
        @(negedge clk);
        start   = 1'b0;
        num_vec = 16'd0;
        k   = 0;
        i   = 0;
        gap = gap_a[0];
        check("busy_in_run", 32'(busy), 32'd1);
        while (i < n && k < BUDGET) begin
            start   = (poke && i == 1) ? 1'b1 : 1'b0;
            num_vec = 16'd2;
            if (gap > 0) begin
                vif.s_valid = 1'b0;
                vif.s_data  = 5'($urandom);
                if (i > 0) begin
                    check("dut_a_hold", 32'(dut_a), 32'(data_a[i-1]));
                    vif.s_exp = ~gate_f(data_a[i-1]);
                end else begin
                    vif.s_exp = 2'($urandom);
                end
                gap--;
            end else begin
                check("s_ready_in_run", 32'(vif.s_ready), 32'd1);
                vif.s_valid = 1'b1;
                vif.s_data  = data_a[i];
                vif.s_exp   = exp_a[i];
                i++;
                if (i < n) gap = gap_a[i];
            end
            @(negedge clk);
            k++;
        end
        vif.s_valid = 1'b0;
        start       = 1'b0;
        num_vec     = 16'd0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        cycles = done ? k : -1;
        err    = err_cnt;
        ff     = first_fail;
        if (poke) begin
            start   = 1'b1;
            num_vec = 16'd3;
        end
        @(negedge clk);
        start   = 1'b0;
        num_vec = 16'd0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
        check("idle_not_ready", 32'(vif.s_ready), 32'd0);
        check("err_hold", 32'(err_cnt), 32'(err));
        check("ff_hold", 32'(first_fail), 32'(ff));
    endtask

    typedef struct {
        int          n;
        int          gap1;
        logic [15:0] wrong_mask;
        bit          poke;
        int          exp_cycles;
        logic [15:0] exp_err;
        logic [15:0] exp_ff;
    } tcase_t;

    initial begin
        tcase_t      tbl [4];
        int          cyc;
        int          dcount;
        logic [15:0] err;
        logic [15:0] ff;

        tbl[0] = '{n: 4, gap1: 0, wrong_mask: 16'h0000, poke: 1'b0, exp_cycles: 7, exp_err: 16'd0, exp_ff: 16'hFFFF};
        tbl[1] = '{n: 5, gap1: 0, wrong_mask: 16'h000A, poke: 1'b0, exp_cycles: 8, exp_err: 16'd2, exp_ff: 16'd1};
        tbl[2] = '{n: 3, gap1: 2, wrong_mask: 16'h0000, poke: 1'b0, exp_cycles: 8, exp_err: 16'd0, exp_ff: 16'hFFFF};
        tbl[3] = '{n: 4, gap1: 0, wrong_mask: 16'h0004, poke: 1'b1, exp_cycles: 7, exp_err: 16'd1, exp_ff: 16'd2};

        vif.s_valid = 1'b0;
        vif.s_data  = 5'd0;
        vif.s_exp   = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(vif.s_ready), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_ff", 32'(first_fail), 32'hFFFF);
        check("rst_dut_a", 32'(dut_a), 32'd0);
        rst = 1'b0;

        // Directed runs from the table.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < tbl[t].n; i++) begin
                data_a[i] = 5'($urandom);
                exp_a[i]  = gate_f(data_a[i]) ^ (tbl[t].wrong_mask[i] ? 2'b01 : 2'b00);
                gap_a[i]  = (i == 1) ? tbl[t].gap1 : 0;
            end
            run_once(tbl[t].n, tbl[t].poke, cyc, err, ff);
            check($sformatf("tbl%0d_cycles", t), 32'(cyc), 32'(tbl[t].exp_cycles));
            check($sformatf("tbl%0d_err", t), 32'(err), 32'(tbl[t].exp_err));
            check($sformatf("tbl%0d_ff", t), 32'(ff), 32'(tbl[t].exp_ff));
        end

        // Empty run: straight to DONE, counters cleared from the previous run.
        @(negedge clk);
        start   = 1'b1;
        num_vec = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_ready", 32'(vif.s_ready), 32'd0);
        check("zero_err", 32'(err_cnt), 32'd0);
        check("zero_ff", 32'(first_fail), 32'hFFFF);
        @(negedge clk);
        check("zero_done_drop", 32'(done), 32'd0);
        check("zero_busy_after", 32'(busy), 32'd0);

        // Reset with three vectors in flight, all of them wrong.
        @(negedge clk);
        start   = 1'b1;
        num_vec = 16'd8;
        @(negedge clk);
        start   = 1'b0;
        num_vec = 16'd0;
        for (int i = 0; i < 3; i++) begin
            vif.s_valid = 1'b1;
            vif.s_data  = 5'($urandom);
            vif.s_exp   = ~gate_f(vif.s_data);
            @(negedge clk);
        end
        vif.s_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_err", 32'(err_cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err_cnt), 32'd0);
        check("midrst_ff", 32'(first_fail), 32'hFFFF);
        check("midrst_dut_a", 32'(dut_a), 32'd0);
        check("midrst_ready", 32'(vif.s_ready), 32'd0);
        rst    = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        check("midrst_still_idle", 32'(busy), 32'd0);

        // Randomized runs against a run-level reference.
        for (int r = 0; r < 10; r++) begin
            int          n;
            int          gaps;
            int          m_err;
            logic [15:0] m_ff;
            n     = $urandom_range(1, 12);
            gaps  = 0;
            m_err = 0;
            m_ff  = 16'hFFFF;
            for (int i = 0; i < n; i++) begin
                data_a[i] = 5'($urandom);
                exp_a[i]  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : gate_f(data_a[i]);
                gap_a[i]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
                gaps      = gaps + gap_a[i];
                if (exp_a[i] != gate_f(data_a[i])) begin
                    m_err++;
                    if (m_ff == 16'hFFFF) m_ff = 16'(i);
                end
            end
            run_once(n, 1'b0, cyc, err, ff);
            check($sformatf("rnd%0d_cycles", r), 32'(cyc), 32'(n + gaps + LAT + 1));
            check($sformatf("rnd%0d_err", r), 32'(err), 32'(m_err));
            check($sformatf("rnd%0d_ff", r), 32'(ff), 32'(m_ff));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
